// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - opcode encodings presented on cmd_op / alu_op / res_op
//   - seq_state_t: sequencer FSM states
//   - fixed result bytes returned on divide-by-zero and ALU timeout
//   - cmd_t: one queued command as stored in the FIFO
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] DIV0_RESULT    = 8'hFF;
   localparam logic [7:0] TIMEOUT_RESULT = 8'h00;

   localparam int unsigned CMD_W = 18;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      WAIT,
      HOLD
   } seq_state_t;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   // Divide by zero is answered locally; the ALU never sees it.
   function automatic logic is_div0(input cmd_t c);
      return (c.op == OP_DIV) && (c.b == 8'h00);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with wrap-around pointers.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored when full)
//   pop,  rdata  read request and head-of-queue data (ignored when empty)
//   full, empty  occupancy flags, derived from the registered count
module cmd_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: queues {op, A, B} commands and serialises each onto the
// byte-wide ALU bus as two beats, then returns the result via valid/ready.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b          command opcode and operands
//   alu_in, alu_op, alu_valid     operand beats towards the ALU
//   alu_o, alu_ready              ALU result and completion strobe
//   res_valid/res_ready           result handshake towards the consumer
//   res_data, res_op, res_err     result byte, its opcode, div0/timeout flag
module alu_cmd_seq
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic [7:0] alu_in,
   output logic [1:0] alu_op,
   output logic       alu_valid,
   input  logic [7:0] alu_o,
   input  logic       alu_ready,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [1:0] res_op,
   output logic       res_err
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   seq_state_t    state;
   cmd_t          wr_cmd;
   cmd_t          rd_cmd;
   logic          full;
   logic          empty;
   logic          pop;
   logic [7:0]    a_q;
   logic [7:0]    b_q;
   logic [1:0]    op_q;
   logic [CW-1:0] cnt;

   assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b};
   assign cmd_ready = !full;
   assign pop       = (state == IDLE) && !empty;

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .wdata (wr_cmd),
      .pop   (pop),
      .rdata (rd_cmd),
      .full  (full),
      .empty (empty)
   );

   // Each state's outputs take effect on the edge taken in that state, so
   // res_valid rises one edge after HOLD is entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         cnt       <= '0;
         alu_in    <= '0;
         alu_op    <= '0;
         alu_valid <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (is_div0(rd_cmd)) begin
                     res_data <= DIV0_RESULT;
                     res_err  <= 1'b1;
                     res_op   <= rd_cmd.op;
                     state    <= HOLD;
                  end else begin
                     a_q   <= rd_cmd.a;
                     b_q   <= rd_cmd.b;
                     op_q  <= rd_cmd.op;
                     state <= SEND_A;
                  end
               end
            end
            SEND_A: begin
               alu_valid <= 1'b1;
               alu_in    <= a_q;
               alu_op    <= op_q;
               state     <= SEND_B;
            end
            SEND_B: begin
               alu_valid <= 1'b1;
               alu_in    <= b_q;
               alu_op    <= op_q;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               alu_valid <= 1'b0;
               if (alu_ready) begin
                  res_data <= alu_o;
                  res_err  <= 1'b0;
                  res_op   <= op_q;
                  state    <= HOLD;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  res_data <= TIMEOUT_RESULT;
                  res_err  <= 1'b1;
                  res_op   <= op_q;
                  state    <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  res_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
